// File: rtl/trigger_capture_if.sv
// Sample-stream, frame-RAM write port and frame handshake bundle for trigger_capture.
// master drives samples and handshakes; slave is the capture engine.
interface trigger_capture_if;
   logic       sample_en;
   logic [7:0] adc_db;
   logic       arm;
   logic       frame_ack;
   logic       wr_en;
   logic [8:0] wr_addr;
   logic [7:0] wr_data;
   logic       frame_ready;
   logic [8:0] frame_start;
   logic       frame_forced;

   modport master (
      output sample_en, adc_db, arm, frame_ack,
      input  wr_en, wr_addr, wr_data, frame_ready, frame_start, frame_forced
   );

   modport slave (
      input  sample_en, adc_db, arm, frame_ack,
      output wr_en, wr_addr, wr_data, frame_ready, frame_start, frame_forced
   );
endinterface

// File: rtl/trigger_capture.sv
// Oscilloscope-style trigger capture into a circular frame RAM (pre/post trigger window).
// Optional auto trigger in continuous mode is enabled by defining TRIG_AUTO_EN.
module trigger_capture #(
   parameter int FRAME_LEN    = 200,
   parameter int PRE_LEN      = 50,
   parameter int AUTO_TIMEOUT = 20000
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [7:0]        trig_level,
   input  logic              trig_edge,
   input  logic              sample_type,
   trigger_capture_if.slave  bus
);
   localparam int POST_LEN = FRAME_LEN - PRE_LEN;

   typedef enum logic [2:0] {IDLE, PRE, ARMED, POST, DONE} state_t;

   state_t     state_reg, state_next;
   logic [9:0] cnt_reg, cnt_next;
   logic [8:0] ptr_reg, ptr_inc;
   logic       mode_reg, mode_next;
   logic [7:0] prev_reg;
   logic       prev_valid_reg, prev_valid_next;
   logic       frame_ready_reg, frame_ready_next;
   logic [8:0] frame_start_reg, frame_start_next;
   logic       wr_en_reg;
   logic [8:0] wr_addr_reg;
   logic [7:0] wr_data_reg;
   logic       capture;
   logic       trig_hit;
   logic       auto_hit;

   assign capture = bus.sample_en &&
                    (state_reg == PRE || state_reg == ARMED || state_reg == POST);
   assign ptr_inc = (ptr_reg == 9'(FRAME_LEN - 1)) ? 9'd0 : ptr_reg + 9'd1;

   always_comb begin
      trig_hit = 1'b0;
      if (prev_valid_reg) begin
         if (trig_edge)
            trig_hit = (prev_reg > trig_level) && (bus.adc_db <= trig_level);
         else
            trig_hit = (prev_reg < trig_level) && (bus.adc_db >= trig_level);
      end
   end

`ifdef TRIG_AUTO_EN
   localparam int AW = $clog2(AUTO_TIMEOUT + 1);
   logic [AW-1:0] auto_cnt_reg;
   logic          forced_reg;

   // Counts ARMED samples; the AUTO_TIMEOUT-th one stands in for a real trigger.
   assign auto_hit = mode_reg && (auto_cnt_reg == AW'(AUTO_TIMEOUT - 1));

   always_ff @(posedge clock) begin
      if (reset) begin
         auto_cnt_reg <= '0;
         forced_reg   <= 1'b0;
      end else begin
         if (state_reg != ARMED)
            auto_cnt_reg <= '0;
         else if (bus.sample_en)
            auto_cnt_reg <= auto_cnt_reg + 1'b1;

         if (state_reg == ARMED && bus.sample_en && auto_hit && !trig_hit)
            forced_reg <= 1'b1;
         else if (state_reg == DONE && bus.frame_ack)
            forced_reg <= 1'b0;
      end
   end

   assign bus.frame_forced = forced_reg;
`else
   assign auto_hit         = 1'b0;
   assign bus.frame_forced = 1'b0;
`endif

   always_comb begin
      state_next       = state_reg;
      cnt_next         = cnt_reg;
      mode_next        = mode_reg;
      prev_valid_next  = prev_valid_reg;
      frame_ready_next = frame_ready_reg;
      frame_start_next = frame_start_reg;
      case (state_reg)
         IDLE: begin
            if (sample_type || bus.arm) begin
               state_next      = PRE;
               mode_next       = sample_type;
               cnt_next        = '0;
               prev_valid_next = 1'b0;
            end
         end
         PRE: begin
            if (bus.sample_en) begin
               prev_valid_next = 1'b1;
               if (cnt_reg == 10'(PRE_LEN - 1)) begin
                  state_next = ARMED;
                  cnt_next   = '0;
               end else begin
                  cnt_next = cnt_reg + 10'd1;
               end
            end
         end
         ARMED: begin
            if (bus.sample_en && (trig_hit || auto_hit)) begin
               // The trigger sample itself is the first post-trigger sample.
               if (POST_LEN == 1) begin
                  state_next       = DONE;
                  frame_ready_next = 1'b1;
                  frame_start_next = ptr_inc;
               end else begin
                  state_next = POST;
                  cnt_next   = 10'd1;
               end
            end
         end
         POST: begin
            if (bus.sample_en) begin
               if (cnt_reg == 10'(POST_LEN - 1)) begin
                  state_next       = DONE;
                  frame_ready_next = 1'b1;
                  frame_start_next = ptr_inc;
               end else begin
                  cnt_next = cnt_reg + 10'd1;
               end
            end
         end
         DONE: begin
            if (bus.frame_ack) begin
               frame_ready_next = 1'b0;
               mode_next        = sample_type;
               cnt_next         = '0;
               prev_valid_next  = 1'b0;
               state_next       = sample_type ? PRE : IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg       <= IDLE;
         cnt_reg         <= '0;
         mode_reg        <= 1'b0;
         prev_reg        <= '0;
         prev_valid_reg  <= 1'b0;
         frame_ready_reg <= 1'b0;
         frame_start_reg <= '0;
         ptr_reg         <= '0;
         wr_en_reg       <= 1'b0;
         wr_addr_reg     <= '0;
         wr_data_reg     <= '0;
      end else begin
         state_reg       <= state_next;
         cnt_reg         <= cnt_next;
         mode_reg        <= mode_next;
         prev_valid_reg  <= prev_valid_next;
         frame_ready_reg <= frame_ready_next;
         frame_start_reg <= frame_start_next;
         wr_en_reg       <= capture;
         if (bus.sample_en)
            prev_reg <= bus.adc_db;
         // wr_addr shows the slot being written; ptr_reg is the next free slot.
         if (capture) begin
            wr_addr_reg <= ptr_reg;
            wr_data_reg <= bus.adc_db;
            ptr_reg     <= ptr_inc;
         end
      end
   end

   assign bus.wr_en       = wr_en_reg;
   assign bus.wr_addr     = wr_addr_reg;
   assign bus.wr_data     = wr_data_reg;
   assign bus.frame_ready = frame_ready_reg;
   assign bus.frame_start = frame_start_reg;
endmodule

// File: tb/tb_trigger_capture.sv
// Directed bench for trigger_capture: single shot, falling edge, continuous, reset abort
// and (when TRIG_AUTO_EN is defined) auto trigger.
module tb_trigger_capture;
   localparam int FL = 200;
   localparam int PL = 50;
   localparam int AT = 10;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic [7:0] trig_level = 8'd128;
   logic       trig_edge = 1'b0;
   logic       sample_type = 1'b0;

   int tests_run = 0;
   int tests_failed = 0;
   int ptr = 0;
   logic [7:0] ram [FL];

   trigger_capture_if bus ();

   trigger_capture #(.FRAME_LEN(FL), .PRE_LEN(PL), .AUTO_TIMEOUT(AT)) dut (
      .clock(clock),
      .reset(reset),
      .trig_level(trig_level),
      .trig_edge(trig_edge),
      .sample_type(sample_type),
      .bus(bus.slave)
   );

   always #5 clock = ~clock;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      ptr = 0;
   endtask

   task automatic send(input logic [7:0] v, input bit exp_wr);
      @(negedge clock);
      check_eq("wr_en_single_cycle", 32'(bus.wr_en), 0);
      bus.sample_en = 1'b1;
      bus.adc_db    = v;
      @(negedge clock);
      bus.sample_en = 1'b0;
      check_eq("wr_en", 32'(bus.wr_en), 32'(exp_wr));
      if (exp_wr) begin
         check_eq("wr_addr", 32'(bus.wr_addr), 32'(ptr));
         check_eq("wr_data", 32'(bus.wr_data), 32'(v));
         ram[ptr] = v;
         ptr = (ptr == FL - 1) ? 0 : ptr + 1;
      end
   endtask

   task automatic pulse_arm();
      @(negedge clock);
      bus.arm = 1'b1;
      @(negedge clock);
      bus.arm = 1'b0;
   endtask

   task automatic pulse_ack();
      @(negedge clock);
      bus.frame_ack = 1'b1;
      @(negedge clock);
      bus.frame_ack = 1'b0;
   endtask

   task automatic check_frame(input string tag, input int start, input logic [7:0] trig_val);
      check_eq({tag, "_ready"}, 32'(bus.frame_ready), 1);
      check_eq({tag, "_start"}, 32'(bus.frame_start), 32'(start));
      check_eq({tag, "_trig_slot"}, 32'(ram[(int'(bus.frame_start) + PL) % FL]), 32'(trig_val));
   endtask

   initial begin
      bus.sample_en = 1'b0;
      bus.adc_db    = 8'd0;
      bus.arm       = 1'b0;
      bus.frame_ack = 1'b0;

      // Reset state
      do_reset();
      check_eq("rst_wr_en", 32'(bus.wr_en), 0);
      check_eq("rst_wr_addr", 32'(bus.wr_addr), 0);
      check_eq("rst_wr_data", 32'(bus.wr_data), 0);
      check_eq("rst_frame_ready", 32'(bus.frame_ready), 0);
      check_eq("rst_frame_start", 32'(bus.frame_start), 0);
      check_eq("rst_frame_forced", 32'(bus.frame_forced), 0);

      // Single shot, rising at 128, ramp: trigger at i=128, 278 writes, start 78
      send(8'd7, 1'b0);
      pulse_arm();
      for (int i = 0; i < 277; i++) send(8'(i), 1'b1);
      check_eq("ss_not_ready_early", 32'(bus.frame_ready), 0);
      send(8'(277), 1'b1);
      check_frame("ss", 78, 8'd128);
      check_eq("ss_forced", 32'(bus.frame_forced), 0);
      send(8'd5, 1'b0);
      pulse_ack();
      check_eq("ss_ready_cleared", 32'(bus.frame_ready), 0);
      send(8'd5, 1'b0);

      // Falling at 100; equal/equal must not trigger; stray arm/ack ignored
      do_reset();
      trig_edge  = 1'b1;
      trig_level = 8'd100;
      pulse_arm();
      for (int i = 0; i < 49; i++) begin
         send(8'd200, 1'b1);
         if (i == 20) pulse_arm();
      end
      send(8'd100, 1'b1);
      send(8'd100, 1'b1);
      pulse_ack();
      send(8'd150, 1'b1);
      send(8'd120, 1'b1);
      send(8'd100, 1'b1);
      for (int i = 0; i < 148; i++) send(8'd90, 1'b1);
      check_eq("fall_not_ready_early", 32'(bus.frame_ready), 0);
      send(8'd90, 1'b1);
      check_frame("fall", 3, 8'd100);
      pulse_ack();

      // Continuous, three frames of 203 writes each: starts 3, 6, 9 with wrap
      do_reset();
      trig_edge   = 1'b0;
      trig_level  = 8'd128;
      sample_type = 1'b1;
      @(negedge clock);
      for (int f = 0; f < 3; f++) begin
         for (int i = 0; i < 53; i++) send(8'd0, 1'b1);
         for (int i = 0; i < 150; i++) send(8'd200, 1'b1);
         check_frame("cont", 3 * (f + 1), 8'd200);
         send(8'd0, 1'b0);
         check_eq("cont_ready_in_done", 32'(bus.frame_ready), 1);
         pulse_ack();
         check_eq("cont_ready_after_ack", 32'(bus.frame_ready), 0);
      end

      // Reset mid-POST aborts with no write; ack in IDLE is ignored
      sample_type = 1'b0;
      do_reset();
      pulse_arm();
      for (int i = 0; i < 50; i++) send(8'd0, 1'b1);
      for (int i = 0; i < 6; i++) send(8'd200, 1'b1);
      @(negedge clock);
      reset = 1'b1;
      bus.sample_en = 1'b1;
      bus.adc_db = 8'd33;
      @(negedge clock);
      reset = 1'b0;
      bus.sample_en = 1'b0;
      ptr = 0;
      check_eq("abort_wr_en", 32'(bus.wr_en), 0);
      check_eq("abort_wr_addr", 32'(bus.wr_addr), 0);
      check_eq("abort_frame_ready", 32'(bus.frame_ready), 0);
      send(8'd44, 1'b0);
      pulse_ack();
      send(8'd45, 1'b0);
      check_eq("abort_still_idle_ready", 32'(bus.frame_ready), 0);

      // Auto trigger: constant 50 under level 128, continuous
      do_reset();
      sample_type = 1'b1;
      @(negedge clock);
      for (int i = 0; i < PL + AT + 148; i++) send(8'd50, 1'b1);
      check_eq("auto_not_ready_early", 32'(bus.frame_ready), 0);
      send(8'd50, 1'b1);
`ifdef TRIG_AUTO_EN
      check_eq("auto_ready", 32'(bus.frame_ready), 1);
      check_eq("auto_forced", 32'(bus.frame_forced), 1);
      check_eq("auto_start", 32'(bus.frame_start), 9);
      sample_type = 1'b0;
      pulse_ack();
      check_eq("auto_forced_cleared", 32'(bus.frame_forced), 0);
      check_eq("auto_ready_cleared", 32'(bus.frame_ready), 0);
`else
      check_eq("auto_ready", 32'(bus.frame_ready), 0);
      check_eq("auto_forced", 32'(bus.frame_forced), 0);
      for (int i = 0; i < 20; i++) send(8'd50, 1'b1);
      check_eq("auto_still_armed", 32'(bus.frame_ready), 0);
`endif

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
